// File: rtl/div_iter.sv
// div_iter: iterative 32-bit radix-2 restoring divider for DIV/DIVU feeding HI/LO.
//
// Ports:
//   clk         in   1   pipeline clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   start       in   1   request a division (sampled in IDLE only)
//   signed_div  in   1   1 = DIV (two's complement), 0 = DIVU
//   cancel      in   1   flush; aborts any operation, wins over start
//   a           in   32  dividend
//   b           in   32  divisor
//   busy        out  1   high while iterating
//   ready       out  1   one-cycle pulse when result is valid (HI/LO write enable)
//   result      out  64  {remainder, quotient}, held until the next completion
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        cancel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        ready,
    output logic [63:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_dvd;
    logic [31:0] r_div;
    logic        r_neg_q;
    logic        r_neg_r;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_upper;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic [31:0] w_rem_fix;
    logic [31:0] w_quo_fix;

    // 0x8000_0000 negates to itself, which is exactly its unsigned magnitude.
    assign w_a_mag   = (signed_div && a[31]) ? -a : a;
    assign w_b_mag   = (signed_div && b[31]) ? -b : b;
    // The dividend register doubles as the quotient: quotient bits shift in at the bottom.
    assign w_upper   = {r_rem, r_dvd[31]};
    assign w_ge      = w_upper >= {1'b0, r_div};
    // When the trial subtract succeeds the difference fits in 32 bits.
    assign w_sub     = w_upper[31:0] - r_div;
    assign w_rem_nxt = w_ge ? w_sub : w_upper[31:0];
    assign w_quo_nxt = {r_dvd[30:0], w_ge};
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    assign busy  = r_state == S_BUSY;
    assign ready = r_state == S_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_rem   <= 32'd0;
            r_dvd   <= 32'd0;
            r_div   <= 32'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            result  <= 64'd0;
        end else if (cancel) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && b == 32'd0) begin
                        result  <= {a, 32'hFFFF_FFFF};
                        r_state <= S_DONE;
                    end else if (start) begin
                        r_dvd   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_rem   <= 32'd0;
                        r_cnt   <= 5'd0;
                        r_neg_q <= signed_div && (a[31] ^ b[31]);
                        r_neg_r <= signed_div && a[31];
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        result  <= {w_rem_fix, w_quo_fix};
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter.
//
// Drives directed divides with hand-computed {remainder, quotient} results and checks
// latency, busy duration, cancel, ignored start, divide-by-zero and async reset.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_chk = 0;
    int n_err = 0;

    div_iter u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one divide and waits for ready; poke drives a competing start while busy.
    task automatic run(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp, input int exp_lat, input bit poke);
        int n;
        int nb;
        bit both;
        @(negedge clk);
        start = 1'b1; signed_div = s; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0003; signed_div = ~s;
        n = 1; nb = 0; both = 0;
        while (!ready && n < 100) begin
            if (busy) nb++;
            start = poke && n == 3;
            @(posedge clk);
            #1;
            n++;
            both |= busy && ready;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(nb), 64'(exp_lat - 1));
        chk({tag, " busy&ready"}, 64'(both), 64'd0);
        chk({tag, " result"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, " idle after"}, {62'd0, busy, ready}, 64'd0);
    endtask

    initial begin
        #3;
        chk("reset outputs", {busy, ready, result[61:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("divu 100/7",        1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},                 33, 0);
        run("div -7/2",          1'b1, 32'hFFFF_FFF9, 32'd2,       {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 0);
        run("div 7/-2",          1'b1, 32'd7,        32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        run("div min/-1",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},        33, 0);
        run("divu min/max",      1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0},        33, 0);
        run("divu 5/0",          1'b0, 32'd5,        32'd0,        {32'd5, 32'hFFFF_FFFF},          1,  0);
        run("div -3/0",          1'b1, 32'hFFFF_FFFD, 32'd0,       {32'hFFFF_FFFD, 32'hFFFF_FFFF},  1,  0);
        run("divu max/1",        1'b0, 32'hFFFF_FFFF, 32'd1,       {32'h0, 32'hFFFF_FFFF},          33, 0);
        run("divu 0/9",          1'b0, 32'd0,        32'd9,        64'd0,                           33, 0);
        run("divu 3/10",         1'b0, 32'd3,        32'd10,       {32'd3, 32'd0},                  33, 0);
        run("div -100/-7",       1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},       33, 0);
        run("divu 1e6/1000",     1'b0, 32'd1000000,  32'd1000,     {32'd0, 32'd1000},               33, 0);
        run("div max/min",       1'b1, 32'h7FFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'h0},        33, 0);
        run("div -1/1",          1'b1, 32'hFFFF_FFFF, 32'd1,       {32'h0, 32'hFFFF_FFFF},          33, 0);
        run("divu ignored start", 1'b0, 32'd100,     32'd7,        {32'd2, 32'd14},                 33, 1);

        // Cancel in cycle 10, then a fresh start in cycle 11 completes in cycle 44.
        begin
            int n;
            @(negedge clk);
            start = 1'b1; signed_div = 1'b0; a = 32'd20; b = 32'd3;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            chk("cancel busy c10", 64'(busy), 64'd1);
            cancel = 1'b1;
            @(posedge clk);
            #1;
            cancel = 1'b0;
            chk("cancel busy c11", {62'd0, busy, ready}, 64'd0);
            chk("cancel result kept", result, {32'd2, 32'd14});
            start = 1'b1; a = 32'd100; b = 32'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
            n = 12;
            while (!ready && n < 150) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("restart ready cycle", 64'(n), 64'd44);
            chk("restart result", result, {32'd2, 32'd14});
            @(posedge clk);
            #1;
        end

        // Cancel together with start in IDLE: nothing starts.
        begin
            @(negedge clk);
            start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd0;
            @(posedge clk);
            #1;
            start = 1'b0; cancel = 1'b0;
            chk("cancel beats start", {62'd0, busy, ready}, 64'd0);
            chk("cancel beats start result", result, {32'd2, 32'd14});
        end

        // Asynchronous reset in cycle 15 of a divide.
        begin
            @(negedge clk);
            start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (14) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            chk("async reset outputs", {busy, ready, result[61:0]}, 64'd0);
            chk("async reset result", result, 64'd0);
            @(negedge clk);
            rst = 1'b0;
        end
        run("post reset 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
